// File: rtl/io_pkg.sv
// Shared types and seven-segment glyphs for the print display path.
// Latency: n/a (package). Backpressure: n/a.
// Glyphs are active-low, bit order {dp,g,f,e,d,c,b,a}.
package io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

    localparam int DIGITS     = 8;
    localparam int MAG_DIGITS = 7;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 32-bit binary to 10-digit BCD, one bit per clock.
// Latency: 32 cycles after start. Backpressure: none; a new start restarts the engine.
// ready is high during the final step, so the result is valid on the following cycle.
module bin2bcd_seq
    import io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] bin,
    output logic [39:0] bcd,
    output logic        ready
);

    logic [31:0] sh;
    logic [39:0] bcd_q;
    logic [39:0] bcd_adj;
    logic [4:0]  cnt;
    logic        active;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh     <= '0;
            bcd_q  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            sh     <= bin;
            bcd_q  <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            bcd_q <= {bcd_adj[38:0], sh[31]};
            sh    <= {sh[30:0], 1'b0};
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31)
                active <= 1'b0;
        end
    end

    assign bcd   = bcd_q;
    assign ready = active && (cnt == 5'd31);

endmodule

// File: rtl/ecall_print_display.sv
// Prints a signed 32-bit ecall value on an 8-digit multiplexed seven-segment display.
// Latency: display/done update 33 cycles after the accepted print_valid edge.
// Backpressure: none; print edges arriving while busy are dropped.
module ecall_print_display
    import io_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        print_valid,
    input  logic [31:0] print_data,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t                   state, state_nxt;
    logic                     pv_q;
    logic                     sign_q;
    logic                     accept;
    logic [31:0]              mag;
    logic [39:0]              bcd;
    logic                     conv_ready;
    logic                     ovf_next;
    logic                     lead;
    logic [DIGITS-1:0][7:0]   disp, disp_next;
    logic                     overflow_q;
    logic                     done_q;
    logic [PSC_W-1:0]         psc;
    logic [2:0]               idx;
    logic [7:0]               an_q, seg_q;

    assign accept = (state == ST_IDLE) && print_valid && !pv_q;
    assign mag    = print_data[31] ? (~print_data + 32'd1) : print_data;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (mag),
        .bcd   (bcd),
        .ready (conv_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            pv_q   <= 1'b0;
            sign_q <= 1'b0;
        end else begin
            state <= state_nxt;
            pv_q  <= print_valid;
            if (accept)
                sign_q <= print_data[31];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept)     state_nxt = ST_CONVERT;
            ST_CONVERT: if (conv_ready) state_nxt = ST_FINISH;
            ST_FINISH:                  state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Leading-zero blanking scans from the top magnitude digit down; digit 0 always shows.
    always_comb begin
        ovf_next  = |bcd[39:28];
        disp_next = {DIGITS{SEG_BLANK}};
        lead      = 1'b1;
        for (int i = MAG_DIGITS - 1; i >= 1; i--) begin
            if (bcd[i*4 +: 4] != 4'd0)
                lead = 1'b0;
            if (!lead)
                disp_next[i] = seg_encode(bcd[i*4 +: 4]);
        end
        disp_next[0] = seg_encode(bcd[3:0]);
        if (sign_q && (bcd[27:0] != 28'd0))
            disp_next[DIGITS-1] = SEG_DASH;
        if (ovf_next)
            disp_next = {DIGITS{SEG_DASH}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp       <= {DIGITS{SEG_BLANK}};
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_FINISH) begin
                disp       <= disp_next;
                overflow_q <= ovf_next;
                done_q     <= 1'b1;
            end
        end
    end

    // Scan runs free of the FSM; an/seg are registered together from the same index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc   <= '0;
            idx   <= '0;
            an_q  <= 8'hFF;
            seg_q <= SEG_BLANK;
        end else begin
            if (psc == PSC_W'(SCAN_DIV - 1)) begin
                psc <= '0;
                idx <= idx + 3'd1;
            end else begin
                psc <= psc + 1'b1;
            end
            an_q  <= ~(8'b1 << idx);
            seg_q <= disp[idx];
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign busy     = (state != ST_IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ecall_print_display.sv
// Directed bench for ecall_print_display with a fast scan (SCAN_DIV=4).
// Expected glyphs and latencies are hand-computed constants.
module tb_ecall_print_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        print_valid;
    logic [31:0] print_data;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        busy;
    logic        done;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    ecall_print_display #(.SCAN_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .print_valid (print_valid),
        .print_data  (print_data),
        .seg         (seg),
        .an          (an),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Drives one print edge and watches 41 edges (k=0 is the accept edge E0).
    task automatic do_print(input logic [31:0] v, input int glitch_k, input int rst_k,
                            output int first_done, output int busy_cnt, output int done_cnt);
        @(negedge clk);
        print_data  = v;
        print_valid = 1'b1;
        first_done  = -1;
        busy_cnt    = 0;
        done_cnt    = 0;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
            end
            if (k == 2) print_valid = 1'b0;
            if (k == glitch_k - 1) begin
                print_valid = 1'b1;
                print_data  = 32'h1111_1111;
            end
            if (k == rst_k - 1) reset = 1'b0;
        end
        print_valid = 1'b0;
    endtask

    task automatic check_disp(input string tag, input logic [7:0][7:0] exp);
        logic [7:0][7:0] got;
        logic [7:0]      sel;
        got = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                sel = ~(8'b1 << i);
                if (an == sel) got[i] = seg;
            end
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_d%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
    endtask

    task automatic print_and_check(input string tag, input logic [31:0] v,
                                   input logic exp_ovf, input logic [7:0][7:0] exp);
        int fd, bc, dc;
        do_print(v, -1, -1, fd, bc, dc);
        chk({tag, "_done_at"}, fd, 33);
        chk({tag, "_busy_cycles"}, bc, 33);
        chk({tag, "_done_count"}, dc, 1);
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        check_disp(tag, exp);
    endtask

    initial begin
        int fd, bc, dc;
        logic [7:0] e_an;

        reset       = 1'b0;
        print_valid = 1'b0;
        print_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {24'd0, an}, 32'hFF);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 36; j++) begin
            @(posedge clk);
            #1;
            e_an = ~(8'b1 << ((j / 4) % 8));
            chk($sformatf("scan_an_%0d", j), {24'd0, an}, {24'd0, e_an});
        end
        chk("scan_seg_blank", {24'd0, seg}, 32'hFF);

        print_and_check("p42", 32'h0000_002A, 1'b0,
            {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hA4});
        print_and_check("pm7", 32'hFFFF_FFF9, 1'b0,
            {8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8});
        print_and_check("p0", 32'h0000_0000, 1'b0,
            {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
        print_and_check("pm100", 32'hFFFF_FF9C, 1'b0,
            {8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0});
        print_and_check("p9999999", 32'h0098_967F, 1'b0,
            {8'hFF, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});
        print_and_check("p10M", 32'h0098_9680, 1'b1, {8{8'hBF}});
        print_and_check("pmin", 32'h8000_0000, 1'b1, {8{8'hBF}});

        // Second edge at E10 and a data change mid-conversion must both be ignored.
        do_print(32'h0000_0315, 10, -1, fd, bc, dc);
        chk("glitch_done_count", dc, 1);
        chk("glitch_done_at", fd, 33);
        chk("glitch_overflow", {31'd0, overflow}, 32'd0);
        check_disp("glitch",
            {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'h80, 8'h90});

        // Reset at E20 of a new conversion aborts it.
        repeat (2) @(negedge clk);
        do_print(32'h0000_0005, -1, 20, fd, bc, dc);
        chk("abort_done_count", dc, 0);
        chk("abort_busy_cycles", bc, 20);
        chk("abort_an", {24'd0, an}, 32'hFF);
        chk("abort_seg", {24'd0, seg}, 32'hFF);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check_disp("abort", {8{8'hFF}});
        chk("abort_overflow", {31'd0, overflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ecall_print_display.md
# ecall_print_display

Downstream consumer of the register file's print-ecall outputs (`io_out` / `a0_data`). On each new print request it:

- captures the 32-bit value and interprets it as signed two's complement;
- converts it to decimal with a sequential shift-add-3 (double-dabble) engine;
- drives the board's 8-digit multiplexed seven-segment display with the result until the next print.

## Interface

Parameters:
- `SCAN_DIV`, default 100000: clk cycles per digit-scan step (1 kHz digit rate at 100 MHz).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `print_valid`  in  1  print request level, driven from `io_out`.
- `print_data`  in  32  value to print, driven from `a0_data`.
- `seg`  out  8  segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}.
- `an`  out  8  digit enables, active-low one-hot; bit 0 is the rightmost digit.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when the display register updates.
- `overflow`  out  1  last printed value did not fit in 7 decimal digits.

## Operation

- Request detect: a registered `pv_q` samples `print_valid`. A request is accepted when `print_valid & ~pv_q` is true in state IDLE.
  - A rising edge that arrives while not in IDLE is dropped, not queued.
  - `pv_q` resets to 0.
- Capture: on accept, latch `sign = print_data[31]`.
  - Magnitude is `sign ? -print_data : print_data` as a 32-bit unsigned value, so -2147483648 gives magnitude 0x8000_0000.
- FSM states: IDLE -> CONVERT -> FINISH -> IDLE.
  - CONVERT: 32 steps, one per clock. Each step adds 3 to every BCD nibble ≥5 in a 40-bit BCD register (10 digits), then shifts {bcd, mag} left by 1.
  - A 5-bit step counter leaves CONVERT after step 31.
  - FINISH: one cycle; loads the display register, pulses `done`, returns to IDLE.
- Overflow: magnitude > 9_999_999 (either of BCD digits 7..9 nonzero) sets `overflow`. All 8 digits then show dash (segment g only).
- Normal display:
  - Digits 0..6 hold BCD digits 0..6, with leading zeros blanked above the most significant nonzero digit.
  - Value 0 shows a single "0" in digit 0.
  - Digit 7 shows dash if `sign` is set and the value is nonzero; otherwise it is blank.
- `dp` is always off (`seg[7]=1`).
- Scan:
  - A prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0..7 and wraps from 7 to 0.
  - `an` selects the current index. `seg` is the encoded glyph for that digit.
  - Scanning runs continuously, independent of the FSM.

## Timing

- Reset values:
  - `an=8'hFF`, `seg=8'hFF`, `busy=0`, `done=0`, `overflow=0`.
  - Display register all blank; FSM in IDLE; digit index 0; prescaler 0.
- Latency:
  - Accept at clock edge E0; steps at E1..E32; FINISH entered at E32.
  - Display register, `overflow` and `done=1` are all updated at E33. `done` clears at E34.
  - `busy` is high from after E0 through E33; it equals `state != IDLE`.
- A request is accepted at the first edge where IDLE and a rising edge of `print_valid` coincide. Back-to-back prints need a `print_valid` low period of at least one cycle between them.
- `print_data` is sampled only at E0; later changes have no effect.
- Reset asserted mid-conversion aborts immediately. The FSM goes to IDLE and the display blanks; no `done` pulse is produced.
- `seg`/`an` are registered, so they change one cycle after a digit-index or display-register update. Both change on the same edge, so there is no glitch between them.

## Structure

- Shared package `io_pkg`:
  - FSM state enum;
  - glyph constants `SEG_0`..`SEG_9`, `SEG_BLANK` (8'hFF) and `SEG_DASH` (8'hBF);
  - `DIGITS=8` and `MAG_DIGITS=7`.
- Sub-module `bin2bcd_seq` holds the 32-step double-dabble engine:
  - inputs `start` and `bin[31:0]`;
  - outputs `bcd[39:0]` and `ready`.
- The top level holds request detection, sign/overflow/blanking logic, the display register and the scan multiplexer.

## Test plan

- Reset, then 0x0000_002A with a `print_valid` rising edge: `done` at E33, `busy` 33 cycles. Digit 0='2', digit 1='4', digits 2..7 blank; `overflow=0`.
- 0xFFFF_FFF9 (-7): digit 0='7', digit 7=dash (`seg` 8'hBF), digits 1..6 blank.
- 0x0000_0000: digit 0='0' (`seg` 8'hC0), all others blank.
- 0x0098_9680 (10_000_000): `overflow=1`, all 8 digits dash. 0x8000_0000 also gives `overflow=1`.
- Second rising edge of `print_valid` at E10 while busy: ignored, only one `done`, display shows the first value. Then assert `reset` at E20 of a new conversion: no `done`, `an=8'hFF`, display blank.
- `SCAN_DIV=4`: `an` sequence FE, FD, FB, … 7F, FE, advancing every 4 cycles.
